// File: rtl/s2p_pkg.sv
// Shared types, default sizes and the parity helper for the serial-to-parallel receiver.
package s2p_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_HOLD   = 2'd3
    } s2p_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Error when the data XOR parity bit disagrees with the chosen sense (0 = even, 1 = odd).
    function automatic logic calc_perr(input logic data_xor, input logic par_bit, input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Single-entry valid/ready output register with a wrapping delivered-word counter.
module s2p_out_reg
    import s2p_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_perr_i,
    input  logic             pready_i,
    output logic [WIDTH-1:0] pdata_o,
    output logic             pvalid_o,
    output logic             perr_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    logic w_handshake;

    assign w_handshake = pvalid_o && pready_i;

    // A load always wins over the handshake so pvalid_o stays high when a new word replaces the old.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pdata_o    <= '0;
            pvalid_o   <= 1'b0;
            perr_o     <= 1'b0;
            word_cnt_o <= '0;
        end else begin
            if (load_i) begin
                pdata_o  <= load_data_i;
                perr_o   <= load_perr_i;
                pvalid_o <= 1'b1;
            end else if (w_handshake) begin
                pvalid_o <= 1'b0;
            end
            if (w_handshake) begin
                word_cnt_o <= word_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: collects WIDTH bits LSB first and presents them on a valid/ready port.
// Optional trailing parity bit enabled by defining SERIAL_PARITY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no bits of the current word received yet
// S_SHIFT  | collecting data bits, bit count = bits received so far
// S_PARITY | all data bits in, waiting for the parity bit
// S_HOLD   | completed word waiting for the output register to drain
module serial_to_parallel_rx
    import s2p_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PARITY_ODD = 0
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic             sdata_i,
    input  logic             svalid_i,
    output logic             sready_o,
    output logic [WIDTH-1:0] pdata_o,
    output logic             pvalid_o,
    input  logic             pready_i,
    output logic             perr_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int BC_W = $clog2(WIDTH + 1);

    s2p_state_t       r_state, w_state_nxt;
    logic [BC_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic             r_perr_hold, w_perr_hold_nxt;
    logic             w_accept;
    logic             w_complete;
    logic             w_load;
    logic             w_load_perr;
    logic             w_perr_new;

    // Held low during reset so the sender sees no acceptance until the block is live.
    assign sready_o = (r_state != S_HOLD) && !rst_i;
    assign w_accept = svalid_i && (r_state != S_HOLD);

`ifdef SERIAL_PARITY_EN
    assign w_perr_new = calc_perr(^r_shreg, sdata_i, PARITY_ODD != 0);
`else
    assign w_perr_new = 1'b0;
`endif

    // Place the accepted data bit at the position given by the bit count.
    always_comb begin
        w_shreg_nxt = r_shreg;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_accept && (r_bit_cnt == BC_W'(k))) begin
                w_shreg_nxt[k] = sdata_i;
            end
        end
    end

    // Next-state, bit count and output-register load decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_complete      = 1'b0;
        w_load          = 1'b0;
        w_load_perr     = w_perr_new;
        w_perr_hold_nxt = r_perr_hold;

        case (r_state)
            S_IDLE, S_SHIFT: begin
                if (w_accept) begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BC_W'(WIDTH - 1)) begin
`ifdef SERIAL_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_complete  = 1'b1;
`endif
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            S_PARITY: begin
                if (w_accept) begin
                    w_complete = 1'b1;
                end
            end
`endif
            S_HOLD: begin
                if (pready_i) begin
                    w_load        = 1'b1;
                    w_load_perr   = r_perr_hold;
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase

        // The completing edge either loads straight through or parks the word in the shift register.
        if (w_complete) begin
            w_bit_cnt_nxt = '0;
            if (!pvalid_o || pready_i) begin
                w_load      = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt     = S_HOLD;
                w_perr_hold_nxt = w_perr_new;
            end
        end
    end

    // FSM state, bit count and shift register.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_perr_hold <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_perr_hold <= w_perr_hold_nxt;
        end
    end

    s2p_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk_i       (sclk_i),
        .rst_i       (rst_i),
        .load_i      (w_load),
        .load_data_i (w_shreg_nxt),
        .load_perr_i (w_load_perr),
        .pready_i    (pready_i),
        .pdata_o     (pdata_o),
        .pvalid_o    (pvalid_o),
        .perr_o      (perr_o),
        .word_cnt_o  (word_cnt_o)
    );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (default WIDTH=8, CNT_W=16, even parity).
module tb_serial_to_parallel_rx;

    logic        sclk_i = 1'b0;
    logic        rst_i;
    logic        sdata_i;
    logic        svalid_i;
    logic        sready_o;
    logic [7:0]  pdata_o;
    logic        pvalid_o;
    logic        pready_i;
    logic        perr_o;
    logic [15:0] word_cnt_o;

    int total = 0;
    int bad   = 0;

    serial_to_parallel_rx dut (
        .sclk_i     (sclk_i),
        .rst_i      (rst_i),
        .sdata_i    (sdata_i),
        .svalid_i   (svalid_i),
        .sready_o   (sready_o),
        .pdata_o    (pdata_o),
        .pvalid_o   (pvalid_o),
        .pready_i   (pready_i),
        .perr_o     (perr_o),
        .word_cnt_o (word_cnt_o)
    );

    always #5 sclk_i = ~sclk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk_i);
        #1;
    endtask

    // Sends one word LSB first (plus a correct even parity bit in the parity build); leaves svalid_i high.
    task automatic send_word(input logic [7:0] d, input bit gaps, input bit ready_on_last);
        logic [8:0] seq;
        int n;
        seq = {^d, d};
        n = 8;
`ifdef SERIAL_PARITY_EN
        n = 9;
`endif
        for (int i = 0; i < n; i++) begin
            if (ready_on_last && i == n - 1) pready_i = 1'b1;
            svalid_i = 1'b1;
            sdata_i  = seq[i];
            tick();
            if (gaps && i != n - 1) begin
                svalid_i = 1'b0;
                sdata_i  = ~sdata_i;
                tick();
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b2b [4];
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h5A; b2b[3] = 8'h81;

        rst_i    = 1'b1;
        svalid_i = 1'b0;
        sdata_i  = 1'b1;
        pready_i = 1'b0;

        // Reset held 3 cycles with svalid_i toggling.
        for (int i = 0; i < 3; i++) begin
            svalid_i = i[0];
            tick();
            chk("rst_sready", sready_o, 0);
        end
        chk("rst_pvalid", pvalid_o, 0);
        chk("rst_pdata", pdata_o, 0);
        chk("rst_perr", perr_o, 0);
        chk("rst_cnt", word_cnt_o, 0);
        rst_i    = 1'b0;
        svalid_i = 1'b0;
        #1;
        chk("post_rst_sready", sready_o, 1);

        // Single word with the sink always ready.
        pready_i = 1'b1;
        send_word(8'hA5, 0, 0);
        svalid_i = 1'b0;
        chk("a5_pdata", pdata_o, 8'hA5);
        chk("a5_pvalid", pvalid_o, 1);
        chk("a5_perr", perr_o, 0);
        chk("a5_cnt_before", word_cnt_o, 0);
        tick();
        chk("a5_pvalid_drop", pvalid_o, 0);
        chk("a5_cnt", word_cnt_o, 1);

        // Gapped word, then a second word while the sink is stalled.
        pready_i = 1'b0;
        send_word(8'h3C, 1, 0);
        svalid_i = 1'b0;
        chk("3c_pdata", pdata_o, 8'h3C);
        chk("3c_pvalid", pvalid_o, 1);
        send_word(8'hC3, 0, 0);
        svalid_i = 1'b0;
        chk("hold_sready", sready_o, 0);
        chk("hold_pdata", pdata_o, 8'h3C);
        chk("hold_pvalid", pvalid_o, 1);
        chk("hold_cnt", word_cnt_o, 1);
        svalid_i = 1'b1;
        tick();
        svalid_i = 1'b0;
        chk("hold_stable_pdata", pdata_o, 8'h3C);
        chk("hold_stable_sready", sready_o, 0);
        pready_i = 1'b1;
        tick();
        chk("release_pdata", pdata_o, 8'hC3);
        chk("release_pvalid", pvalid_o, 1);
        chk("release_cnt", word_cnt_o, 2);
        chk("release_sready", sready_o, 1);
        tick();
        chk("c3_pvalid_drop", pvalid_o, 0);
        chk("c3_cnt", word_cnt_o, 3);

        // Back-to-back words with svalid_i held high.
        for (int w = 0; w < 4; w++) begin
            send_word(b2b[w], 0, 0);
            chk("b2b_pdata", pdata_o, b2b[w]);
            chk("b2b_pvalid", pvalid_o, 1);
            chk("b2b_cnt", word_cnt_o, 3 + w);
        end
        svalid_i = 1'b0;
        tick();
        chk("b2b_pvalid_drop", pvalid_o, 0);
        chk("b2b_cnt_final", word_cnt_o, 7);

        // Completion on the same edge as the handshake of the previous word.
        pready_i = 1'b0;
        send_word(8'h11, 0, 0);
        svalid_i = 1'b0;
        tick();
        chk("sim_first_pdata", pdata_o, 8'h11);
        chk("sim_first_pvalid", pvalid_o, 1);
        send_word(8'h22, 0, 1);
        svalid_i = 1'b0;
        chk("sim_pdata", pdata_o, 8'h22);
        chk("sim_pvalid", pvalid_o, 1);
        chk("sim_cnt", word_cnt_o, 8);
        tick();
        chk("sim_pvalid_drop", pvalid_o, 0);
        chk("sim_cnt_final", word_cnt_o, 9);

        // Reset part-way through a word discards the partial bits.
        for (int i = 0; i < 5; i++) begin
            svalid_i = 1'b1;
            sdata_i  = 1'b1;
            tick();
        end
        svalid_i = 1'b0;
        rst_i    = 1'b1;
        tick();
        rst_i    = 1'b0;
        chk("midrst_cnt", word_cnt_o, 0);
        chk("midrst_pvalid", pvalid_o, 0);
        send_word(8'h0F, 0, 0);
        svalid_i = 1'b0;
        chk("0f_pdata", pdata_o, 8'h0F);
        chk("0f_pvalid", pvalid_o, 1);
        tick();
        chk("0f_pvalid_drop", pvalid_o, 0);
        chk("0f_cnt", word_cnt_o, 1);

`ifdef SERIAL_PARITY_EN
        // Even parity: 8'h07 has odd weight, so parity bit 1 is correct and 0 is an error.
        for (int p = 1; p >= 0; p--) begin
            logic [8:0] seq;
            seq = {p[0], 8'h07};
            for (int i = 0; i < 9; i++) begin
                svalid_i = 1'b1;
                sdata_i  = seq[i];
                tick();
            end
            svalid_i = 1'b0;
            chk("par_pdata", pdata_o, 8'h07);
            chk("par_pvalid", pvalid_o, 1);
            chk("par_perr", perr_o, (p == 1) ? 0 : 1);
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
